// File: rtl/wb_mem_tester_pkg.sv
// Shared types and helpers for the Wishbone memory tester: FSM state
// encoding, the deterministic test pattern and the byte-select constant.
package wb_mem_tester_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_GAP   = 3'd2,
    ST_READ  = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

  localparam logic [3:0] SEL_ALL = 4'hF;

  // Pattern word for index i: upper half is the index XORed with A5A5 so
  // that stuck or swapped halves are caught, lower half is the raw index.
  function automatic logic [31:0] pat(input logic [15:0] i);
    return {16'hA5A5 ^ i, i};
  endfunction

endpackage

// File: rtl/wb_mem_tester.sv
// Wishbone master self-test: writes NWORDS pattern words starting at
// BASE_ADR, reads them back and compares. Bus errors, timeouts and read
// mismatches are counted; the first failing byte address is latched.
module wb_mem_tester
  import wb_mem_tester_pkg::*;
#(
  parameter int unsigned NWORDS   = 256,
  parameter logic [31:0] BASE_ADR = 32'h0,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [15:0] err_count,
  output logic [31:0] first_err_adr,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [31:0] wb_adr,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_dat_ms,
  input  logic [31:0] wb_dat_sm,
  input  logic        wb_ack,
  input  logic        wb_err,
  input  logic        wb_rty
);

  // A one-cycle timeout still needs a one-bit counter.
  localparam int unsigned   TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [15:0]   LAST_IDX = 16'(NWORDS - 1);

  state_e        state_q, state_d;
  logic [15:0]   idx_q, idx_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          rty_q, rty_d;          // stb withheld for one cycle after rty
  logic [15:0]   err_count_q, err_count_d;
  logic [31:0]   first_err_adr_q, first_err_adr_d;

  logic          active;
  logic          stb;
  logic [31:0]   adr_cur;
  logic          term_err, term_rty, term_ack, term_to;
  logic          advance, mismatch, bad;

  // Bus-phase decode and termination priority (err > rty > ack > timeout).
  always_comb begin
    active   = (state_q == ST_WRITE) || (state_q == ST_READ);
    stb      = active && !rty_q;
    adr_cur  = BASE_ADR + {14'b0, idx_q, 2'b00};
    term_err = stb && wb_err;
    term_rty = stb && !wb_err && wb_rty;
    term_ack = stb && !wb_err && !wb_rty && wb_ack;
    term_to  = stb && !wb_err && !wb_rty && !wb_ack && (tmo_q == TMO_LAST);
    advance  = term_err || term_ack || term_to;
    mismatch = (state_q == ST_READ) && term_ack && (wb_dat_sm != pat(idx_q));
    bad      = term_err || term_to || mismatch;
  end

  // Next-state logic for the run sequencer and its bookkeeping registers.
  always_comb begin
    state_d         = state_q;
    idx_d           = idx_q;
    tmo_d           = tmo_q;
    rty_d           = rty_q;
    err_count_d     = err_count_q;
    first_err_adr_d = first_err_adr_q;

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d         = ST_WRITE;
          idx_d           = 16'd0;
          tmo_d           = '0;
          rty_d           = 1'b0;
          err_count_d     = 16'd0;
          first_err_adr_d = 32'd0;
        end
      end

      ST_WRITE, ST_READ: begin
        if (rty_q) begin
          // Strobe-low cycle after a retry; reissue next cycle from zero.
          rty_d = 1'b0;
          tmo_d = '0;
        end else if (term_rty) begin
          rty_d = 1'b1;
          tmo_d = '0;
        end else if (advance) begin
          tmo_d = '0;
          if (idx_q == LAST_IDX) begin
            idx_d   = 16'd0;
            state_d = (state_q == ST_WRITE) ? ST_GAP : ST_DONE;
          end else begin
            idx_d = idx_q + 16'd1;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
        end

        if (bad) begin
          if (err_count_q != 16'hFFFF) begin
            err_count_d = err_count_q + 16'd1;
          end
          // A zero count means no earlier failure in this run.
          if (err_count_q == 16'd0) begin
            first_err_adr_d = adr_cur;
          end
        end
      end

      ST_GAP: begin
        idx_d   = 16'd0;
        tmo_d   = '0;
        state_d = ST_READ;
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // State and bookkeeping registers with asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= ST_IDLE;
      idx_q           <= 16'd0;
      tmo_q           <= '0;
      rty_q           <= 1'b0;
      err_count_q     <= 16'd0;
      first_err_adr_q <= 32'd0;
    end else begin
      state_q         <= state_d;
      idx_q           <= idx_d;
      tmo_q           <= tmo_d;
      rty_q           <= rty_d;
      err_count_q     <= err_count_d;
      first_err_adr_q <= first_err_adr_d;
    end
  end

  // Outputs decode straight from registered state so reset clears them at once.
  assign wb_cyc        = active;
  assign wb_stb        = stb;
  assign wb_we         = (state_q == ST_WRITE);
  assign wb_adr        = active ? adr_cur : 32'd0;
  assign wb_sel        = stb ? SEL_ALL : 4'h0;
  assign wb_dat_ms     = (state_q == ST_WRITE) ? pat(idx_q) : 32'd0;
  assign busy          = (state_q == ST_WRITE) || (state_q == ST_GAP) ||
                         (state_q == ST_READ);
  assign done          = (state_q == ST_DONE);
  assign pass          = done && (err_count_q == 16'd0);
  assign err_count     = err_count_q;
  assign first_err_adr = first_err_adr_q;

endmodule
